// File: rtl/dbf_fine_apod_ch_pkg.sv
// rtl/dbf_fine_apod_ch_pkg.sv - shared widths, fine-delay coefficient table and rounding helper
package dbf_fine_apod_ch_pkg;

    localparam int INPUT_WD    = 14;
    localparam int COEF_WD     = 16;
    localparam int APO_WD      = 16;
    localparam int ADDR_WD     = 12;
    localparam int PHASE_WD    = 3;
    localparam int NUM_TAPS    = 4;
    localparam int NUM_PHASES  = 1 << PHASE_WD;
    localparam int LUT_DEPTH   = 1 << ADDR_WD;
    localparam int ROUND_SHIFT = 15;
    localparam int PROD_WD     = INPUT_WD + COEF_WD;
    localparam int SUM_WD      = 32;
    localparam int MULT_WD     = SUM_WD + APO_WD;

    typedef logic signed [INPUT_WD-1:0] sample_t;
    typedef logic signed [COEF_WD-1:0]  coef_t;
    typedef logic signed [PROD_WD-1:0]  prod_t;
    typedef logic signed [SUM_WD-1:0]   sum_t;
    typedef logic signed [MULT_WD-1:0]  mult_t;

    // valid flag and apodisation weight travelling alongside the datapath
    typedef struct packed {
        logic                     vld;
        logic signed [APO_WD-1:0] apo;
    } stage_ctl_t;

    // Q1.15 polyphase rows; tap 0 multiplies the newest sample. Each row sums to 32767.
    localparam coef_t COEF_TABLE [NUM_PHASES][NUM_TAPS] = '{
        '{ 16'sd0,     16'sd32767, 16'sd0,     16'sd0    },
        '{-16'sd1024,  16'sd29695, 16'sd4608, -16'sd512  },
        '{-16'sd1536,  16'sd25599, 16'sd9728, -16'sd1024 },
        '{-16'sd1792,  16'sd20479, 16'sd15360,-16'sd1280 },
        '{-16'sd1536,  16'sd17919, 16'sd17919,-16'sd1535 },
        '{-16'sd1280,  16'sd15360, 16'sd20479,-16'sd1792 },
        '{-16'sd1024,  16'sd9728,  16'sd25599,-16'sd1536 },
        '{-16'sd512,   16'sd4608,  16'sd29695,-16'sd1024 }
    };

    localparam mult_t ROUND_ADD = mult_t'(1 << (ROUND_SHIFT - 1));
    localparam mult_t SAT_MAX   = mult_t'(32'sh7fffffff);
    localparam mult_t SAT_MIN   = mult_t'(32'sh80000000);

    // round-half-up, arithmetic shift back to Q0, clamp to the signed 32-bit range
    function automatic sum_t round_sat(input mult_t p);
        mult_t r;
        r = (p + ROUND_ADD) >>> ROUND_SHIFT;
        if (r > SAT_MAX) begin
            return 32'sh7fffffff;
        end else if (r < SAT_MIN) begin
            return 32'sh80000000;
        end
        return r[SUM_WD-1:0];
    endfunction

endpackage

// File: rtl/dbf_fine_apod_ch_if.sv
// rtl/dbf_fine_apod_ch_if.sv - sample, LUT-load and result signals of the fine-delay channel
interface dbf_fine_apod_ch_if import dbf_fine_apod_ch_pkg::*; ();

    logic signed [INPUT_WD-1:0] fine_din;
    logic                       fine_din_valid;
    logic signed [APO_WD-1:0]   apo_din;
    logic [ADDR_WD-1:0]         lut_addr;
    logic [PHASE_WD-1:0]        lut_wdata;
    logic                       lut_we;
    logic signed [SUM_WD-1:0]   fine_dout;
    logic                       fine_dout_valid;

    modport master (
        output fine_din, fine_din_valid, apo_din, lut_addr, lut_wdata, lut_we,
        input  fine_dout, fine_dout_valid
    );

    modport slave (
        input  fine_din, fine_din_valid, apo_din, lut_addr, lut_wdata, lut_we,
        output fine_dout, fine_dout_valid
    );

endinterface

// File: rtl/dbf_fd_coef_rom.sv
// rtl/dbf_fd_coef_rom.sv - combinational 8x4 fractional-delay coefficient ROM
module dbf_fd_coef_rom
    import dbf_fine_apod_ch_pkg::*;
(
    input  logic [PHASE_WD-1:0] phase,
    output coef_t               coef [NUM_TAPS]
);

    // select one polyphase row
    always_comb begin
        for (int k = 0; k < NUM_TAPS; k++) begin
            coef[k] = COEF_TABLE[phase][k];
        end
    end

endmodule

// File: rtl/dbf_fine_apod_ch.sv
// rtl/dbf_fine_apod_ch.sv - per-channel fine delay (4-tap polyphase FIR) with apodisation, 4-stage pipeline
module dbf_fine_apod_ch
    import dbf_fine_apod_ch_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_en,
    input  logic              start,
    dbf_fine_apod_ch_if.slave bus
);

    // flush covers both the transmit window and the gap between receive lines
    logic flush;
    logic accept;
    assign flush  = tx_en | ~start;
    assign accept = ~flush & bus.fine_din_valid;

    logic [PHASE_WD-1:0] lut_mem [LUT_DEPTH];
    logic [PHASE_WD-1:0] s1_phase;
    logic [ADDR_WD-1:0]  depth;
    sample_t             taps [NUM_TAPS];
    stage_ctl_t          s1_ctl;
    stage_ctl_t          s2_ctl;
    stage_ctl_t          s3_ctl;
    coef_t               coef [NUM_TAPS];
    prod_t               s2_prod [NUM_TAPS];
    sum_t                sum_c;
    sum_t                s3_sum;
    mult_t               apod_c;
    sum_t                result_c;

    // host load of the fine-phase LUT; writes during an active line are ignored
    always_ff @(posedge clk) begin
        if (bus.lut_we && !start) begin
            lut_mem[bus.lut_addr] <= bus.lut_wdata;
        end
    end

    // registered LUT read of the phase for the sample being accepted this cycle
    always_ff @(posedge clk) begin
        s1_phase <= lut_mem[depth];
    end

    // S1: tap shift register, weight capture and saturating depth counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                taps[k] <= '0;
            end
            depth  <= '0;
            s1_ctl <= '0;
        end else if (flush) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                taps[k] <= '0;
            end
            depth  <= '0;
            s1_ctl <= '0;
        end else begin
            s1_ctl.vld <= accept;
            if (accept) begin
                taps[0] <= bus.fine_din;
                for (int k = 1; k < NUM_TAPS; k++) begin
                    taps[k] <= taps[k-1];
                end
                s1_ctl.apo <= bus.apo_din;
                if (depth != '1) begin
                    depth <= depth + 1'b1;
                end
            end
        end
    end

    dbf_fd_coef_rom u_coef_rom (
        .phase (s1_phase),
        .coef  (coef)
    );

    // S2: per-tap products against the selected coefficient row
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_ctl <= '0;
            for (int k = 0; k < NUM_TAPS; k++) begin
                s2_prod[k] <= '0;
            end
        end else begin
            s2_ctl.vld <= s1_ctl.vld & ~flush;
            s2_ctl.apo <= s1_ctl.apo;
            for (int k = 0; k < NUM_TAPS; k++) begin
                s2_prod[k] <= prod_t'(taps[k]) * prod_t'(coef[k]);
            end
        end
    end

    // tap sum; rows sum to at most unity so 32 bits cannot overflow
    always_comb begin
        sum_c = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            sum_c = sum_c + sum_t'(s2_prod[k]);
        end
    end

    // S3: register the FIR sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_ctl <= '0;
            s3_sum <= '0;
        end else begin
            s3_ctl.vld <= s2_ctl.vld & ~flush;
            s3_ctl.apo <= s2_ctl.apo;
            s3_sum     <= sum_c;
        end
    end

    // apodisation product with rounding back to 32 bits
    always_comb begin
        apod_c   = mult_t'(s3_sum) * mult_t'($signed(s3_ctl.apo));
        result_c = round_sat(apod_c);
    end

    // S4: output register, forced to zero whenever the result is not valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.fine_dout       <= '0;
            bus.fine_dout_valid <= 1'b0;
        end else if (flush || !s3_ctl.vld) begin
            bus.fine_dout       <= '0;
            bus.fine_dout_valid <= 1'b0;
        end else begin
            bus.fine_dout       <= result_c;
            bus.fine_dout_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dbf_fine_apod_ch.sv
// tb/tb_dbf_fine_apod_ch.sv - directed vectors plus reference-model scoreboard for dbf_fine_apod_ch
module tb_dbf_fine_apod_ch;
    import dbf_fine_apod_ch_pkg::*;

    typedef struct {
        int phase;
        int apo;
        int x0;
        int x1;
        int x2;
        int x3;
        int exp;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic tx_en = 1'b0;
    logic start = 1'b0;

    dbf_fine_apod_ch_if bus ();

    dbf_fine_apod_ch dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tx_en (tx_en),
        .start (start),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int ref_coef [8][4] = '{
        '{    0, 32767,     0,     0},
        '{-1024, 29695,  4608,  -512},
        '{-1536, 25599,  9728, -1024},
        '{-1792, 20479, 15360, -1280},
        '{-1536, 17919, 17919, -1535},
        '{-1280, 15360, 20479, -1792},
        '{-1024,  9728, 25599, -1536},
        '{ -512,  4608, 29695, -1024}
    };

    int    m_x [4];
    int    m_depth;
    int    m_lut [4096];
    logic  e_vld [8];
    int    e_dout [8];
    int    cyc;
    int    checks;
    int    failures;
    string tag;
    vec_t  tv [9];

    function automatic int ref_round_sat(input longint p);
        longint r;
        r = (p + 64'sd16384) >>> 15;
        if (r > 64'sd2147483647) return 32'sh7fffffff;
        if (r < -64'sd2147483648) return 32'sh80000000;
        return int'(r);
    endfunction

    // drive one cycle, advance the model, then compare the output after the edge
    task automatic step(input logic s, input logic t, input logic v, input int din, input int apo,
                        input logic we, input int addr, input int wd);
        int slot;
        int ph;
        int acc;
        start              = s;
        tx_en              = t;
        bus.fine_din_valid = v;
        bus.fine_din       = din[13:0];
        bus.apo_din        = apo[15:0];
        bus.lut_we         = we;
        bus.lut_addr       = addr[11:0];
        bus.lut_wdata      = wd[2:0];
        slot         = (cyc + 3) % 8;
        e_vld[slot]  = 1'b0;
        e_dout[slot] = 0;
        if (t || !s) begin
            for (int k = 0; k < 4; k++) m_x[k] = 0;
            m_depth = 0;
            for (int j = 0; j < 3; j++) begin
                e_vld[(cyc + j) % 8]  = 1'b0;
                e_dout[(cyc + j) % 8] = 0;
            end
            if (!s && we) m_lut[addr] = wd;
        end else if (v) begin
            for (int k = 3; k > 0; k--) m_x[k] = m_x[k-1];
            m_x[0] = din;
            ph  = m_lut[m_depth];
            acc = 0;
            for (int k = 0; k < 4; k++) acc += m_x[k] * ref_coef[ph][k];
            e_vld[slot]  = 1'b1;
            e_dout[slot] = ref_round_sat(longint'(acc) * longint'(apo));
            if (m_depth < 4095) m_depth++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.fine_dout_valid !== e_vld[cyc % 8] || bus.fine_dout !== e_dout[cyc % 8]) begin
            failures++;
            $display("FAIL %s edge %0d: got valid=%0b dout=%0d, expected valid=%0b dout=%0d",
                     tag, cyc, bus.fine_dout_valid, bus.fine_dout, e_vld[cyc % 8], e_dout[cyc % 8]);
        end
        cyc++;
    endtask

    task automatic idle_line(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
    endtask

    task automatic rand_samples(input int n);
        for (int i = 0; i < n; i++)
            step(1'b1, 1'b0, 1'b1, int'($urandom_range(16383)) - 8192,
                 int'($urandom_range(65535)) - 32768, 1'b0, 0, 0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        m_depth  = 0;
        for (int k = 0; k < 4; k++) m_x[k] = 0;
        for (int k = 0; k < 8; k++) begin
            e_vld[k]  = 1'b0;
            e_dout[k] = 0;
        end
        for (int a = 0; a < 4096; a++) m_lut[a] = 0;

        // phase, apo, x0 (newest) .. x3 (oldest), rounded result
        tv[0] = '{0,  32767,     0,  1000,     0,     0,  32766000};
        tv[1] = '{0, -32768, -8192, -8192, -8192, -8192, 268427264};
        tv[2] = '{4,  32767,   100,   100,   100,   100,   3276600};
        tv[3] = '{2,  16384,     0,     1,     0,     0,     12800};
        tv[4] = '{7,  32767,     0,     0,     1,     0,     29694};
        tv[5] = '{3, -32768,     1,    -1,     1,    -1,      5631};
        tv[6] = '{0,      1,     0,    -1,     0,     0,        -1};
        tv[7] = '{0,      1,     0,     1,     0,     0,         1};
        tv[8] = '{1,  32767,  8191, -8192,  8191, -8192, -209704192};

        bus.fine_din       = '0;
        bus.fine_din_valid = 1'b0;
        bus.apo_din        = '0;
        bus.lut_addr       = '0;
        bus.lut_wdata      = '0;
        bus.lut_we         = 1'b0;

        tag = "reset";
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
        rst_n = 1'b1;
        tag = "idle";
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 0);

        tag = "lut_fill";
        for (int a = 0; a < 4096; a++) step(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, a, a % 8);

        tag = "vec";
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 3, tv[i].phase);
            step(1'b1, 1'b0, 1'b1, tv[i].x3, tv[i].apo, 1'b0, 0, 0);
            step(1'b1, 1'b0, 1'b1, tv[i].x2, tv[i].apo, 1'b0, 0, 0);
            step(1'b1, 1'b0, 1'b1, tv[i].x1, tv[i].apo, 1'b0, 0, 0);
            step(1'b1, 1'b0, 1'b1, tv[i].x0, tv[i].apo, 1'b0, 0, 0);
            idle_line(3);
            checks++;
            if (bus.fine_dout_valid !== 1'b1 || bus.fine_dout !== tv[i].exp) begin
                failures++;
                $display("FAIL vec%0d: got valid=%0b dout=%0d, expected valid=1 dout=%0d",
                         i, bus.fine_dout_valid, bus.fine_dout, tv[i].exp);
            end
        end

        tag = "impulse";
        for (int a = 0; a < 8; a++) step(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, a, 0);
        step(1'b1, 1'b0, 1'b1, 1000, 32767, 1'b0, 0, 0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, 0, 32767, 1'b0, 0, 0);
        idle_line(4);

        tag = "stream";
        for (int a = 0; a < 64; a++) step(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, a, int'($urandom_range(7)));
        rand_samples(64);
        idle_line(4);

        tag = "tx_flush";
        step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
        rand_samples(5);
        step(1'b1, 1'b1, 1'b1, 1234, 20000, 1'b0, 0, 0);
        rand_samples(6);
        idle_line(4);

        tag = "lut_guard";
        step(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 5, 2);
        step(1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 5, 7);
        rand_samples(8);
        idle_line(4);

        tag = "depth_sat";
        step(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 4095, 5);
        step(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 4094, 1);
        rand_samples(4100);
        idle_line(4);

        tag = "async_rst";
        step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
        rand_samples(6);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.fine_dout_valid !== 1'b0 || bus.fine_dout !== 32'sd0) begin
            failures++;
            $display("FAIL async_rst_immediate: got valid=%0b dout=%0d, expected valid=0 dout=0",
                     bus.fine_dout_valid, bus.fine_dout);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
        rst_n = 1'b1;
        tag = "post_rst";
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
        rand_samples(6);
        idle_line(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
